select_encode_scoreboard: RTL and testbench
===========================================

Name: select_encode_scoreboard

Overview:
- Parametrised successor to the Mini-SRC register select-and-encode logic.
- Extracts the Ra/Rb/Rc fields from IR and decodes the selected field to one-hot register-file enables (R_in / R_out). Produces the sign- or zero-extended C constant.
- Adds a per-register pending-write scoreboard for multi-cycle and overlapped instructions, with a stall output when a read operand has an outstanding write.
- Sits between the IR and the register file, driven by the control unit.

Parameters:
- NUM_REGS, 16, number of general registers (power of 2).
- REG_W, $clog2(NUM_REGS), register field width (derived; do not override).
- IR_W, 32, instruction register width.
- RA_LSB, 23, LSB of the Ra field.
- RB_LSB, 19, LSB of the Rb field.
- RC_LSB, 15, LSB of the Rc field.
- C_W, 19, width of the C constant field (bits C_W-1:0).
- PEND_W, 2, width of each pending counter (max outstanding writes per register = 2^PEND_W-1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- IRin  in  IR_W  instruction register contents
- Gra, Grb, Grc  in  1 each  field select
- Rin  in  1  write selected register
- Rout  in  1  drive selected register onto bus
- BAout  in  1  base-address read (R0 reads as zero)
- issue  in  1  mark Ra of IRin as pending write
- retire  in  1  a pending write completes
- retire_reg  in  REG_W  register whose write completes
- R_in  out  NUM_REGS  one-hot register load enables
- R_out  out  NUM_REGS  one-hot register drive enables
- ba_zero  out  1  drive constant 0 onto bus instead of R0
- C_sext  out  IR_W  C field sign-extended from bit C_W-1
- C_zext  out  IR_W  C field zero-extended
- stall  out  1  selected read register has a pending write, or issue blocked
- sel_err  out  1  more than one of Gra/Grb/Grc asserted this cycle
- sb_err  out  1  sticky: retire to a register with count 0

Behaviour:
- Decode is combinational, with zero latency from IRin/G*/Rin/Rout/BAout to R_in, R_out, ba_zero, C_*, sel_err, stall.
- Field select priority: Gra > Grb > Grc. sel_err = more than one asserted. With no G* asserted, R_in = R_out = 0.
- R_in = onehot(sel) when Rin, else 0.
- R_out = onehot(sel) when (Rout | BAout), except when BAout and sel==0: then R_out = 0 and ba_zero = 1.
- The scoreboard holds one PEND_W-bit counter per register, updated on the rising clock edge.
  - Issue increments count[Ra]; retire decrements count[retire_reg].
  - Issue and retire to the same register in the same cycle leave the count unchanged.
  - Issue when count[Ra] is at maximum is dropped, and stall is asserted that cycle (the control unit must hold).
  - Retire when count is 0 is ignored and sets sb_err, which stays set until reset.
- stall = (Rout | BAout) & selected register valid & count[sel] != 0 & ~(BAout & sel==0), OR the issue-full condition.
- Stall is advisory only: R_out is not gated by stall.
- Reset (any cycle, including mid-sequence): all counters 0, sb_err 0.
  - Combinational outputs follow their inputs. With all control inputs low, all outputs are 0 except C_sext/C_zext, which follow IRin.

Decomposition:
- Package sel_enc_pkg holds the default field LSBs, C_W, NUM_REGS, and a function onehot(idx) returning NUM_REGS bits.
- Sub-module pend_counter (PEND_W) is instantiated per register via generate. It has inc/dec inputs, saturate-at-max and floor-at-zero behaviour, and outputs: nonzero, full, underflow.

Test Plan:
- IRin=0x0188_0000 (Ra=3, Rb=1), Gra+Rin -> R_in=0x0008, R_out=0. Then Grb+Rout -> R_out=0x0002.
- Grb+BAout with Rb=0 -> R_out=0, ba_zero=1. Same with Rb=5 -> R_out=0x0020, ba_zero=0.
- C field 0x40000 -> C_sext=0xFFFC_0000, C_zext=0x0004_0000. C field 0x3FFFF -> both 0x0003_FFFF.
- Issue with Ra=7 for 1 cycle, then Gra+Rout on Ra=7 -> stall=1. Retire retire_reg=7 -> next cycle stall=0.
- Issue Ra=4 three times (PEND_W=2), then a fourth issue -> stall=1 and count stays 3. Same-cycle issue+retire on 4 -> count stays 3. Then 3 retires -> 0.
- Retire reg 9 with count 0 -> sb_err=1 sticky. Gra+Grc together -> sel_err=1, Ra chosen. Reset mid-sequence -> counts 0, sb_err 0, stall 0.

Source files
------------

// File: rtl/select_encode_scoreboard_pkg.sv
// Shared defaults and helpers for the register select/encode block and its
// pending-write scoreboard.
package sel_enc_pkg;
  localparam int NUM_REGS_DEF = 16;
  localparam int IR_W_DEF     = 32;
  localparam int RA_LSB_DEF   = 23;
  localparam int RB_LSB_DEF   = 19;
  localparam int RC_LSB_DEF   = 15;
  localparam int C_W_DEF      = 19;
  localparam int PEND_W_DEF   = 2;

  // onehot() is sized for the largest register file supported; callers truncate.
  localparam int ONEHOT_MAX = 64;
  localparam int ONEHOT_IW  = 6;

  typedef enum logic [1:0] {FLD_RA, FLD_RB, FLD_RC} fld_e;

  function automatic logic [ONEHOT_MAX-1:0] onehot(input logic [ONEHOT_IW-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction
endpackage

// File: rtl/select_encode_scoreboard_pend_counter.sv
// Outstanding-write counter for one register: saturates at max, floors at zero.
module pend_counter #(
  parameter int PEND_W = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nonzero,
  output logic full,
  output logic underflow
);
  logic [PEND_W-1:0] cnt_q, cnt_d;

  assign nonzero = |cnt_q;
  assign full    = &cnt_q;

  // Simultaneous inc and dec cancel, so neither saturation nor underflow applies.
  always_comb begin
    cnt_d     = cnt_q;
    underflow = 1'b0;
    if (inc && !dec) begin
      if (!full) cnt_d = cnt_q + PEND_W'(1);
    end else if (dec && !inc) begin
      if (nonzero) cnt_d = cnt_q - PEND_W'(1);
      else         underflow = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
endmodule

// File: rtl/select_encode_scoreboard.sv
// IR field select / one-hot register enable decode, C-constant extension and a
// per-register pending-write scoreboard that raises an advisory stall.
module select_encode_scoreboard
  import sel_enc_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int REG_W    = $clog2(NUM_REGS),
  parameter int IR_W     = IR_W_DEF,
  parameter int RA_LSB   = RA_LSB_DEF,
  parameter int RB_LSB   = RB_LSB_DEF,
  parameter int RC_LSB   = RC_LSB_DEF,
  parameter int C_W      = C_W_DEF,
  parameter int PEND_W   = PEND_W_DEF
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [IR_W-1:0]     IRin,
  input  logic                Gra,
  input  logic                Grb,
  input  logic                Grc,
  input  logic                Rin,
  input  logic                Rout,
  input  logic                BAout,
  input  logic                issue,
  input  logic                retire,
  input  logic [REG_W-1:0]    retire_reg,
  output logic [NUM_REGS-1:0] R_in,
  output logic [NUM_REGS-1:0] R_out,
  output logic                ba_zero,
  output logic [IR_W-1:0]     C_sext,
  output logic [IR_W-1:0]     C_zext,
  output logic                stall,
  output logic                sel_err,
  output logic                sb_err
);
  logic [REG_W-1:0]    ra, rb, rc, sel;
  logic                sel_vld, same_reg, rd_busy, issue_full;
  fld_e                fld;
  logic [NUM_REGS-1:0] oh, inc, dec, nonzero, full, underflow;
  logic                sb_err_q, sb_err_d;
  logic                unused_ir;

  assign unused_ir = ^IRin;

  always_comb begin
    ra      = IRin[RA_LSB +: REG_W];
    rb      = IRin[RB_LSB +: REG_W];
    rc      = IRin[RC_LSB +: REG_W];
    sel_vld = Gra | Grb | Grc;
    sel_err = (Gra & Grb) | (Gra & Grc) | (Grb & Grc);

    if (Gra)      fld = FLD_RA;
    else if (Grb) fld = FLD_RB;
    else          fld = FLD_RC;
    case (fld)
      FLD_RA:  sel = ra;
      FLD_RB:  sel = rb;
      default: sel = rc;
    endcase

    oh      = sel_vld ? NUM_REGS'(onehot(ONEHOT_IW'(sel))) : '0;
    R_in    = Rin ? oh : '0;
    // A base-address read of R0 substitutes a constant zero on the bus.
    ba_zero = BAout & sel_vld & (sel == '0);
    R_out   = ((Rout | BAout) & ~ba_zero) ? oh : '0;

    C_zext  = {{(IR_W-C_W){1'b0}}, IRin[C_W-1:0]};
    C_sext  = {{(IR_W-C_W){IRin[C_W-1]}}, IRin[C_W-1:0]};

    for (int i = 0; i < NUM_REGS; i++) begin
      inc[i] = issue  & (ra == REG_W'(i));
      dec[i] = retire & (retire_reg == REG_W'(i));
    end

    same_reg   = issue & retire & (retire_reg == ra);
    issue_full = issue & full[ra] & ~same_reg;
    rd_busy    = (Rout | BAout) & sel_vld & nonzero[sel] & ~ba_zero;
    stall      = rd_busy | issue_full;

    sb_err_d   = sb_err_q | (|underflow);
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pend
    pend_counter #(.PEND_W(PEND_W)) u_cnt (
      .clock     (clock),
      .reset     (reset),
      .inc       (inc[g]),
      .dec       (dec[g]),
      .nonzero   (nonzero[g]),
      .full      (full[g]),
      .underflow (underflow[g])
    );
  end

  always_ff @(posedge clock) begin
    if (reset) sb_err_q <= 1'b0;
    else       sb_err_q <= sb_err_d;
  end

  assign sb_err = sb_err_q;
endmodule

// File: tb/tb_select_encode_scoreboard.sv
// Self-checking bench: decode vector table, directed scoreboard sequences and
// randomized traffic against a counts-per-register reference model.
module tb_select_encode_scoreboard;
  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] IRin;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, issue, retire;
  logic [3:0]  retire_reg;
  logic [15:0] R_in, R_out;
  logic        ba_zero, stall, sel_err, sb_err;
  logic [31:0] C_sext, C_zext;

  int n_chk  = 0;
  int n_fail = 0;
  int cnt_m[16];
  bit err_m;

  typedef struct {
    logic [31:0] ir;
    logic [5:0]  g;     // {Gra,Grb,Grc,Rin,Rout,BAout}
    logic [15:0] rin;
    logic [15:0] rout;
    logic        bz;
    logic        se;
    logic [31:0] cs;
    logic [31:0] cz;
  } vec_t;
  vec_t tv[11];

  select_encode_scoreboard dut (
    .clock(clock), .reset(reset), .IRin(IRin),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .issue(issue), .retire(retire), .retire_reg(retire_reg),
    .R_in(R_in), .R_out(R_out), .ba_zero(ba_zero), .C_sext(C_sext), .C_zext(C_zext),
    .stall(stall), .sel_err(sel_err), .sb_err(sb_err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic [5:0] g, input bit iss = 0,
                       input bit ret = 0, input int rr = 0, input bit rst = 0);
    IRin = ir;
    {Gra, Grb, Grc, Rin, Rout, BAout} = g;
    issue = iss; retire = ret; retire_reg = 4'(rr); reset = rst;
  endtask

  // Expected outputs derived directly from the field/priority/counter rules.
  task automatic check_model(input string tag);
    int ra, rb, rc, idx;
    bit v, bz, st, se;
    logic [31:0] e_in, e_out, c, cs;
    ra  = int'((IRin >> 23) & 32'hF);
    rb  = int'((IRin >> 19) & 32'hF);
    rc  = int'((IRin >> 15) & 32'hF);
    v   = Gra || Grb || Grc;
    idx = Gra ? ra : (Grb ? rb : rc);
    bz  = BAout && v && idx == 0;
    e_in  = (Rin && v) ? (32'd1 << idx) : 32'd0;
    e_out = ((Rout || BAout) && v && !bz) ? (32'd1 << idx) : 32'd0;
    st  = ((Rout || BAout) && v && !bz && cnt_m[idx] != 0) ||
          (issue && cnt_m[ra] == 3 && !(retire && int'(retire_reg) == ra));
    se  = (int'(Gra) + int'(Grb) + int'(Grc)) > 1;
    c   = IRin & 32'h7FFFF;
    cs  = (c >= 32'h40000) ? c - 32'h80000 : c;
    chk({tag, ".R_in"},    32'(R_in),    e_in);
    chk({tag, ".R_out"},   32'(R_out),   e_out);
    chk({tag, ".ba_zero"}, 32'(ba_zero), 32'(bz));
    chk({tag, ".stall"},   32'(stall),   32'(st));
    chk({tag, ".sel_err"}, 32'(sel_err), 32'(se));
    chk({tag, ".sb_err"},  32'(sb_err),  32'(err_m));
    chk({tag, ".C_sext"},  C_sext,       cs);
    chk({tag, ".C_zext"},  C_zext,       c);
  endtask

  task automatic model_edge();
    int ra, rr;
    ra = int'((IRin >> 23) & 32'hF);
    rr = int'(retire_reg);
    if (reset) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      err_m = 0;
    end else if (!(issue && retire && rr == ra)) begin
      if (issue && cnt_m[ra] < 3) cnt_m[ra]++;
      if (retire) begin
        if (cnt_m[rr] > 0) cnt_m[rr]--;
        else               err_m = 1;
      end
    end
  endtask

  task automatic step(input string tag);
    #1;
    check_model(tag);
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  initial begin
    tv[0]  = '{32'h0188_0000, 6'b100100, 16'h0008, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[1]  = '{32'h0188_0000, 6'b010010, 16'h0000, 16'h0002, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[2]  = '{32'h0180_0000, 6'b010001, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0};
    tv[3]  = '{32'h0028_0000, 6'b010001, 16'h0000, 16'h0020, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[4]  = '{32'h0004_0000, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'hFFFC_0000, 32'h0004_0000};
    tv[5]  = '{32'h0003_FFFF, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0003_FFFF, 32'h0003_FFFF};
    tv[6]  = '{32'h0188_0000, 6'b101010, 16'h0000, 16'h0008, 1'b0, 1'b1, 32'h0, 32'h0};
    tv[7]  = '{32'h0000_0000, 6'b000000, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0};
    tv[8]  = '{32'h0005_0000, 6'b001110, 16'h0400, 16'h0400, 1'b0, 1'b0, 32'hFFFD_0000, 32'h0005_0000};
    tv[9]  = '{32'h0000_0000, 6'b100011, 16'h0000, 16'h0000, 1'b1, 1'b0, 32'h0, 32'h0};
    tv[10] = '{32'h0188_0000, 6'b000010, 16'h0000, 16'h0000, 1'b0, 1'b0, 32'h0, 32'h0};

    drive(32'h0, 6'b0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk("rst.R_in",    32'(R_in),    32'h0);
    chk("rst.R_out",   32'(R_out),   32'h0);
    chk("rst.ba_zero", 32'(ba_zero), 32'h0);
    chk("rst.stall",   32'(stall),   32'h0);
    chk("rst.sel_err", 32'(sel_err), 32'h0);
    chk("rst.sb_err",  32'(sb_err),  32'h0);
    chk("rst.C_sext",  C_sext,       32'h0);

    // Combinational decode table, scoreboard empty.
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].ir, tv[i].g);
      #1;
      chk($sformatf("tv%0d.R_in", i),    32'(R_in),    32'(tv[i].rin));
      chk($sformatf("tv%0d.R_out", i),   32'(R_out),   32'(tv[i].rout));
      chk($sformatf("tv%0d.ba_zero", i), 32'(ba_zero), 32'(tv[i].bz));
      chk($sformatf("tv%0d.sel_err", i), 32'(sel_err), 32'(tv[i].se));
      chk($sformatf("tv%0d.stall", i),   32'(stall),   32'h0);
      chk($sformatf("tv%0d.C_sext", i),  C_sext,       tv[i].cs);
      chk($sformatf("tv%0d.C_zext", i),  C_zext,       tv[i].cz);
    end
    @(negedge clock);

    // Issue Ra=7, read it back, retire it.
    drive(32'h0380_0000, 6'b000000, 1);
    step("iss7");
    drive(32'h0380_0000, 6'b100010);
    #1 chk("rd7.stall", 32'(stall), 32'h1);
    step("rd7");
    drive(32'h0380_0000, 6'b100010, 0, 1, 7);
    #1 chk("rd7ret.stall", 32'(stall), 32'h1);
    step("rd7ret");
    drive(32'h0380_0000, 6'b100010);
    #1 chk("rd7done.stall", 32'(stall), 32'h0);
    step("rd7done");

    // Saturate Ra=4, overflow issue, same-cycle issue+retire, drain.
    repeat (3) begin
      drive(32'h0200_0000, 6'b000000, 1);
      step("iss4");
    end
    drive(32'h0200_0000, 6'b000000, 1);
    #1 chk("iss4full.stall", 32'(stall), 32'h1);
    step("iss4full");
    drive(32'h0200_0000, 6'b000000, 1, 1, 4);
    step("iss4ret4");
    for (int i = 0; i < 3; i++) begin
      drive(32'h0200_0000, 6'b000000, 0, 1, 4);
      step("ret4");
      drive(32'h0200_0000, 6'b100010);
      #1 chk($sformatf("drain%0d.stall", i), 32'(stall), (i < 2) ? 32'h1 : 32'h0);
      step("rd4");
    end

    // Underflow on reg 9 is sticky.
    drive(32'h0, 6'b000000, 0, 1, 9);
    step("ret9");
    drive(32'h0, 6'b000000);
    #1 chk("sb_err.set", 32'(sb_err), 32'h1);
    step("idle");
    step("idle");
    #1 chk("sb_err.sticky", 32'(sb_err), 32'h1);

    // Reset mid-sequence clears counters and sb_err.
    drive(32'h0380_0000, 6'b000000, 1);
    step("iss7a");
    step("iss7b");
    drive(32'h0380_0000, 6'b100010, 0, 0, 0, 1);
    step("midrst");
    drive(32'h0380_0000, 6'b100010);
    #1;
    chk("postrst.stall",  32'(stall),  32'h0);
    chk("postrst.sb_err", 32'(sb_err), 32'h0);
    step("postrst");

    // Randomized traffic, register indices biased low to hit saturation.
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ir;
      int ra;
      ra = $urandom_range(0, 3);
      ir = ($urandom & ~(32'hF << 23)) | (32'(ra) << 23);
      drive(ir, 6'($urandom), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            $urandom_range(0, 3), $urandom_range(0, 59) == 0);
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
